// File: rtl/divmod_seq.sv
// Sequential restoring divider: one quotient bit per clock, with optional
// two's-complement operands and defined divide-by-zero / overflow results.
module divmod_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] mod
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sa_q, sa_d;
    logic             sq_q, sq_d;
    logic             dz_q, dz_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] mod_q, mod_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             neg_a, neg_b;

    // rem < divisor is invariant, so the kept difference always fits WIDTH bits
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};
    assign neg_a   = signed_mode & a[WIDTH-1];
    assign neg_b   = signed_mode & b[WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sq_d    = sq_q;
        dz_d    = dz_q;
        ready_d = ready_q;
        error_d = error_q;
        div_d   = div_q;
        mod_d   = mod_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    sa_d    = neg_a;
                    sq_d    = neg_a ^ neg_b;
                    dz_d    = (b == '0);
                    rem_d   = '0;
                    // on divide-by-zero the raw dividend is kept for mod
                    quo_d   = (b == '0) ? a : (neg_a ? -a : a);
                    dvs_d   = neg_b ? -b : b;
                    cnt_d   = CW'(WIDTH);
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    state_d = (b == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (!trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    div_d   = '1;
                    mod_d   = quo_q;
                    error_d = 1'b1;
                end else begin
                    div_d   = sq_q ? -quo_q : quo_q;
                    mod_d   = sa_q ? -rem_q : rem_q;
                    error_d = 1'b0;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sa_q    <= 1'b0;
            sq_q    <= 1'b0;
            dz_q    <= 1'b0;
            ready_q <= 1'b1;
            error_q <= 1'b0;
            div_q   <= '0;
            mod_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sa_q    <= sa_d;
            sq_q    <= sq_d;
            dz_q    <= dz_d;
            ready_q <= ready_d;
            error_q <= error_d;
            div_q   <= div_d;
            mod_q   <= mod_d;
        end
    end

    assign ready = ready_q;
    assign error = error_q;
    assign div   = div_q;
    assign mod   = mod_q;
endmodule
